// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM controller arbiter.
package sram_arb_pkg;

    localparam int ARB_ADDR_W = 18;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_e;

    typedef struct packed {
        logic                  wr;
        logic [ARB_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            bmask;
    } arb_cmd_t;

endpackage

// File: rtl/sram_arb_timer.sv
// Watchdog for the arbiter WAIT state: clearable up-counter with a sticky expire flag.
module sram_arb_timer #(
    parameter int TIMEOUT_CYC = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_reg;
    logic             expired_reg;

    // Counting stops once expired, so the flag holds until the next clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_reg   <= '0;
            expired_reg <= 1'b0;
        end else if (i_clear) begin
            count_reg   <= '0;
            expired_reg <= 1'b0;
        end else if (i_enable && !expired_reg) begin
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST_CNT) begin
                expired_reg <= 1'b1;
            end
        end
    end

    assign o_expired = expired_reg;

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of the 32-bit SRAM controller (port 0 = LSU, port 1 = loader/debug).
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_p0_req,
    input  logic              i_p0_wr,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [31:0]       i_p0_wdata,
    input  logic [3:0]        i_p0_bmask,
    output logic              o_p0_ack,
    output logic              o_p0_err,
    output logic [31:0]       o_p0_rdata,

    input  logic              i_p1_req,
    input  logic              i_p1_wr,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [31:0]       i_p1_wdata,
    input  logic [3:0]        i_p1_bmask,
    output logic              o_p1_ack,
    output logic              o_p1_err,
    output logic [31:0]       o_p1_rdata,

    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [31:0]       o_sram_wdata,
    output logic [3:0]        o_sram_bmask,
    output logic              o_sram_wren,
    output logic              o_sram_rden,
    input  logic [31:0]       i_sram_rdata,
    input  logic              i_sram_ack,

    output logic              o_busy
);

    arb_state_e state_reg;
    arb_cmd_t   cmd_reg;
    arb_cmd_t   cmd_p0;
    arb_cmd_t   cmd_p1;
    logic       owner_reg;
    logic       grant;
    logic       wren_reg;
    logic       rden_reg;
    logic       expired;
    logic       txn_done;
    logic       txn_err;

    logic [1:0]  port_ack;
    logic [1:0]  port_err;
    logic [31:0] port_rdata [2];

    always_comb begin
        cmd_p0       = '0;
        cmd_p0.wr    = i_p0_wr;
        cmd_p0.addr  = ARB_ADDR_W'(i_p0_addr);
        cmd_p0.wdata = i_p0_wdata;
        cmd_p0.bmask = i_p0_bmask;
        cmd_p1       = '0;
        cmd_p1.wr    = i_p1_wr;
        cmd_p1.addr  = ARB_ADDR_W'(i_p1_addr);
        cmd_p1.wdata = i_p1_wdata;
        cmd_p1.bmask = i_p1_bmask;
    end

`ifdef SRAM_ARB_RR_EN
    logic last_grant_reg;

    always_comb begin
        grant = PORT_0;
        if (i_p0_req && i_p1_req) begin
            grant = ~last_grant_reg;
        end else if (i_p1_req) begin
            grant = PORT_1;
        end
    end
`else
    assign grant = i_p0_req ? PORT_0 : PORT_1;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg      <= ARB_IDLE;
            cmd_reg        <= '0;
            owner_reg      <= PORT_0;
            wren_reg       <= 1'b0;
            rden_reg       <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_grant_reg <= PORT_1;
`endif
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (i_p0_req || i_p1_req) begin
                        cmd_reg        <= (grant == PORT_1) ? cmd_p1 : cmd_p0;
                        owner_reg      <= grant;
                        wren_reg       <= (grant == PORT_1) ? i_p1_wr : i_p0_wr;
                        rden_reg       <= (grant == PORT_1) ? ~i_p1_wr : ~i_p0_wr;
`ifdef SRAM_ARB_RR_EN
                        last_grant_reg <= grant;
`endif
                        state_reg      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    wren_reg  <= 1'b0;
                    rden_reg  <= 1'b0;
                    state_reg <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (txn_done) begin
                        state_reg <= ARB_IDLE;
                    end
                end
                default: begin
                    wren_reg  <= 1'b0;
                    rden_reg  <= 1'b0;
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    // The watchdog restarts from zero on the first WAIT cycle of every transaction.
    sram_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (state_reg == ARB_ISSUE),
        .i_enable  (state_reg == ARB_WAIT),
        .o_expired (expired)
    );

    // A real ack beats a watchdog expiry landing in the same cycle.
    assign txn_done = (state_reg == ARB_WAIT) && (i_sram_ack || expired);
    assign txn_err  = (state_reg == ARB_WAIT) && !i_sram_ack && expired;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign port_ack[gi]   = txn_done && (owner_reg == 1'(gi));
            assign port_err[gi]   = port_ack[gi] && txn_err;
            assign port_rdata[gi] = (port_ack[gi] && !txn_err && !cmd_reg.wr) ? i_sram_rdata : '0;
        end
    endgenerate

    assign o_p0_ack     = port_ack[0];
    assign o_p0_err     = port_err[0];
    assign o_p0_rdata   = port_rdata[0];
    assign o_p1_ack     = port_ack[1];
    assign o_p1_err     = port_err[1];
    assign o_p1_rdata   = port_rdata[1];

    assign o_sram_addr  = ADDR_W'(cmd_reg.addr);
    assign o_sram_wdata = cmd_reg.wdata;
    assign o_sram_bmask = cmd_reg.bmask;
    assign o_sram_wren  = wren_reg;
    assign o_sram_rden  = rden_reg;
    assign o_busy       = (state_reg != ARB_IDLE);

endmodule
